// File: rtl/ghost_mode_pkg.sv
// Shared types and schedule constants for the ghost mode scheduler.
package ghost_mode_pkg;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    FRIGHT  = 2'd2
  } mode_e;

  // Prefixed so the literals do not collide with mode_e::FRIGHT.
  typedef enum logic {
    ST_SCHED  = 1'b0,
    ST_FRIGHT = 1'b1
  } state_e;

  localparam logic [2:0] LAST_PHASE = 3'd7;

  localparam logic [4:0] PHASE_DUR_S [0:6] = '{5'd7, 5'd20, 5'd7, 5'd20, 5'd5, 5'd20, 5'd5};

  // Final sec_cnt value of a timed phase; the last phase has no duration.
  function automatic logic [4:0] phase_last_sec(input logic [2:0] ph);
    logic [4:0] r;
    r = '1;
    for (int unsigned i = 0; i < 7; i++) begin
      if (ph == 3'(i)) r = PHASE_DUR_S[i] - 5'd1;
    end
    return r;
  endfunction

  function automatic mode_e mode_for_phase(input logic [2:0] ph);
    return ph[0] ? CHASE : SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_second_tick_gen.sv
// One-second strobe prescaler: counts 0..CLOCK_FREQ_HZ-1 while enabled.
module second_tick_gen #(
  parameter int CLOCK_FREQ_HZ = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (CLOCK_FREQ_HZ > 1) ? $clog2(CLOCK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLOCK_FREQ_HZ - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_comb tick = en && (cnt == LAST);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase schedule with pellet-triggered fright.
// Optional flash output enabled by defining FRIGHT_FLASH_EN.
module ghost_mode_scheduler #(
  parameter int CLOCK_FREQ_HZ = 25_000_000,
  parameter int FRIGHT_S      = 6,
  parameter int FLASH_S       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_start,
  input  logic       pause,
  input  logic       pellet_eaten,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic       fright_flash,
  output logic [2:0] phase
);

  import ghost_mode_pkg::*;

  localparam int FW = $clog2(FRIGHT_S + 1);
  localparam logic [FW-1:0] FRIGHT_LAST = FW'(FRIGHT_S - 1);

  if (FRIGHT_S < 1 || FRIGHT_S > 31 || FLASH_S < 0 || FLASH_S >= FRIGHT_S) begin : g_cfg_check
    $error("ghost_mode_scheduler: invalid FRIGHT_S/FLASH_S");
  end

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [2:0]    phase_q, phase_d;
  logic [4:0]    sec_q, sec_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          mc_q, mc_d;
  logic          flash_q, flash_d;
  logic          tick;

  // A pellet or level restart discards the partial second in progress.
  second_tick_gen #(.CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (pellet_eaten | level_start),
    .en   (!pause),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCHED;
      mode_q  <= SCATTER;
      phase_q <= '0;
      sec_q   <= '0;
      fcnt_q  <= '0;
      mc_q    <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      sec_q   <= sec_d;
      fcnt_q  <= fcnt_d;
      mc_q    <= mc_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    sec_d   = sec_q;
    fcnt_d  = fcnt_q;
    mc_d    = 1'b0;

    if (level_start) begin
      state_d = ST_SCHED;
      mode_d  = SCATTER;
      phase_d = '0;
      sec_d   = '0;
      fcnt_d  = '0;
    end else if (pellet_eaten) begin
      state_d = ST_FRIGHT;
      mode_d  = FRIGHT;
      fcnt_d  = '0;
      mc_d    = 1'b1;
    end else if (tick) begin
      case (state_q)
        ST_SCHED: begin
          if (phase_q != LAST_PHASE && sec_q == phase_last_sec(phase_q)) begin
            phase_d = phase_q + 3'd1;
            sec_d   = '0;
            mode_d  = mode_for_phase(phase_q + 3'd1);
            mc_d    = 1'b1;
          end else if (sec_q != '1) begin
            sec_d = sec_q + 5'd1;
          end
        end
        ST_FRIGHT: begin
          // Fright exit resumes the frozen schedule without a reversal.
          if (fcnt_q == FRIGHT_LAST) begin
            state_d = ST_SCHED;
            mode_d  = mode_for_phase(phase_q);
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        default: state_d = ST_SCHED;
      endcase
    end

`ifdef FRIGHT_FLASH_EN
    flash_d = (state_d == ST_FRIGHT) && (fcnt_d >= FW'(FRIGHT_S - FLASH_S));
`else
    flash_d = 1'b0;
`endif
  end

  assign mode         = mode_q;
  assign mode_change  = mc_q;
  assign fright_flash = flash_q;
  assign phase        = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a second-level model.
module tb_ghost_mode_scheduler;

  localparam int N        = 10;
  localparam int FRIGHT_S = 6;
  localparam int FLASH_S  = 2;
`ifdef FRIGHT_FLASH_EN
  localparam int FLASH_EN = 1;
`else
  localparam int FLASH_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level_start = 1'b0;
  logic       pause = 1'b0;
  logic       pellet_eaten = 1'b0;
  logic [1:0] mode;
  logic       mode_change;
  logic       fright_flash;
  logic [2:0] phase;

  ghost_mode_scheduler #(
    .CLOCK_FREQ_HZ(N),
    .FRIGHT_S     (FRIGHT_S),
    .FLASH_S      (FLASH_S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .level_start  (level_start),
    .pause        (pause),
    .pellet_eaten (pellet_eaten),
    .mode         (mode),
    .mode_change  (mode_change),
    .fright_flash (fright_flash),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles within the current second, seconds elapsed, phase index.
  int dur [0:6] = '{7, 20, 7, 20, 5, 20, 5};
  int m_cyc = 0, m_phase = 0, m_sec = 0, m_fsec = 0;
  bit m_fright = 0;
  int exp_mode = 0, exp_mc = 0, exp_flash = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    bit second_done;
    if (rst || level_start) begin
      m_cyc = 0; m_phase = 0; m_sec = 0; m_fsec = 0; m_fright = 0; exp_mc = 0;
      if (rst) chk_en = 1;
    end else begin
      second_done = !pause && (m_cyc == N - 1);
      exp_mc = 0;
      if (pellet_eaten) begin
        m_fright = 1; m_fsec = 0; m_cyc = 0; exp_mc = 1;
      end else begin
        if (!pause) m_cyc = (m_cyc + 1) % N;
        if (second_done) begin
          if (m_fright) begin
            if (m_fsec + 1 == FRIGHT_S) m_fright = 0;
            else m_fsec++;
          end else if (m_phase < 7) begin
            m_sec++;
            if (m_sec == dur[m_phase]) begin
              m_phase++; m_sec = 0; exp_mc = 1;
            end
          end else if (m_sec < 31) begin
            m_sec++;
          end
        end
      end
    end
    exp_mode  = m_fright ? 2 : (m_phase % 2);
    exp_flash = (FLASH_EN != 0 && m_fright && m_fsec >= FRIGHT_S - FLASH_S) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mode", 32'(mode), 32'(exp_mode));
      check("mode_change", 32'(mode_change), 32'(exp_mc));
      check("fright_flash", 32'(fright_flash), 32'(exp_flash));
      check("phase", 32'(phase), 32'(m_phase));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pellet_pulse();
    pellet_eaten = 1'b1;
    step(1);
    pellet_eaten = 1'b0;
  endtask

  initial begin
    int pulses;
    int pause_left;

    step(2);
    check("reset_mode", 32'(mode), 0);
    check("reset_phase", 32'(phase), 0);
    check("reset_mc", 32'(mode_change), 0);
    check("reset_flash", 32'(fright_flash), 0);
    rst = 1'b0;

    step(69);
    check("pre_switch_mode", 32'(mode), 0);
    step(1);
    check("switch_mode", 32'(mode), 1);
    check("switch_phase", 32'(phase), 1);
    check("switch_mc", 32'(mode_change), 1);
    step(1);
    check("switch_mc_end", 32'(mode_change), 0);

    step(30);
    pellet_pulse();
    check("fright_mode", 32'(mode), 2);
    check("fright_mc", 32'(mode_change), 1);
    step(39);
    check("flash_pre", 32'(fright_flash), 0);
    step(1);
    check("flash_on", 32'(fright_flash), 32'(FLASH_EN));
    step(19);
    check("fright_hold", 32'(mode), 2);
    step(1);
    check("fright_exit_mode", 32'(mode), 1);
    check("fright_exit_mc", 32'(mode_change), 0);
    check("fright_exit_flash", 32'(fright_flash), 0);
    check("fright_exit_phase", 32'(phase), 1);

    pellet_pulse();
    step(29);
    pellet_pulse();
    check("repellet_mode", 32'(mode), 2);
    check("repellet_mc", 32'(mode_change), 1);
    step(59);
    check("repellet_hold", 32'(mode), 2);
    step(1);
    check("repellet_exit", 32'(mode), 1);
    check("repellet_exit_mc", 32'(mode_change), 0);

    pellet_pulse();
    step(45);
    level_start = 1'b1;
    step(1);
    level_start = 1'b0;
    check("ls_mode", 32'(mode), 0);
    check("ls_phase", 32'(phase), 0);
    check("ls_mc", 32'(mode_change), 0);
    check("ls_flash", 32'(fright_flash), 0);

    step(30);
    pause = 1'b1;
    step(100);
    check("pause_mode", 32'(mode), 0);
    pause = 1'b0;
    step(39);
    check("pause_pre_switch", 32'(mode), 0);
    step(1);
    check("pause_switch", 32'(mode), 1);
    check("pause_switch_mc", 32'(mode_change), 1);

    level_start = 1'b1;
    step(1);
    level_start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 890; i++) begin
      step(1);
      if (mode_change === 1'b1) pulses++;
    end
    check("full_pulses", 32'(pulses), 7);
    check("full_phase", 32'(phase), 7);
    check("full_mode", 32'(mode), 1);

    pause_left = 0;
    for (int i = 0; i < 6000; i++) begin
      pellet_eaten = ($urandom_range(0, 59) == 0);
      level_start  = ($urandom_range(0, 1499) == 0);
      rst          = ($urandom_range(0, 3999) == 0);
      if (pause_left > 0) begin
        pause_left--;
      end else begin
        pause = 1'b0;
        if ($urandom_range(0, 199) == 0) begin
          pause = 1'b1;
          pause_left = $urandom_range(1, 60);
        end
      end
      step(1);
    end
    pellet_eaten = 1'b0;
    level_start  = 1'b0;
    rst          = 1'b0;
    pause        = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
